// File: rtl/core_pkg.sv
// Shared core definitions: opcode constants, scoreboard slot type, flush FSM states
// and opcode classification helpers used by the hazard controller.
package core_pkg;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       is_load;
    } sb_slot_t;

    typedef enum logic {StRun, StFlush} flush_state_t;

    function automatic logic opc_writes_rd(input logic [6:0] opc);
        case (opc)
            LOAD, OP_IMM, OP, LUI, AUIPC, JAL, JALR: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic opc_uses_rs1(input logic [6:0] opc);
        case (opc)
            LUI, AUIPC, JAL: return 1'b0;
            default:         return 1'b1;
        endcase
    endfunction

    function automatic logic opc_uses_rs2(input logic [6:0] opc);
        case (opc)
            OP, STORE, BRANCH: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fwd_cmp.sv
// Forwarding comparator for one source register: picks the MEM-bound or WB-bound
// producer, with the MEM-bound (younger) producer taking priority.
module fwd_cmp
    import core_pkg::*;
(
    input  logic [4:0] rs,
    input  sb_slot_t   mem_slot,
    input  sb_slot_t   wb_slot,
    output logic       fwd_mem,
    output logic       fwd_wb
);

    logic mem_hit;
    logic wb_hit;
    logic unused_load_bits;

    assign mem_hit = mem_slot.valid && mem_slot.wr && (mem_slot.rd == rs);
    assign wb_hit  = wb_slot.valid && wb_slot.wr && (wb_slot.rd == rs);

    assign fwd_mem = mem_hit;
    assign fwd_wb  = wb_hit && !mem_hit;

    assign unused_load_bits = mem_slot.is_load ^ wb_slot.is_load;

endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage hazard controller: EX/MEM/WB shadow scoreboard, registered forward
// selects, load-use stall and post-branch flush. HAZARD_PERF_EN adds stall/flush counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    input  logic [6:0]  dec_opcode,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        branch_taken,
    output logic        forward_mem_ex_rs1,
    output logic        forward_mem_ex_rs2,
    output logic        forward_wb_ex_rs1,
    output logic        forward_wb_ex_rs2,
    output logic        stall,
`ifdef HAZARD_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        flush
);

    localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

    sb_slot_t     ex_q, mem_q, wb_q, ex_d;
    flush_state_t state_q;
    logic [2:0]   cnt_q;
    logic         rs1_used, rs2_used;
    logic         load_use, flush_req;
    logic         rs1_mem, rs1_wb, rs2_mem, rs2_wb;
    logic         unused_wb;

    assign rs1_used = opc_uses_rs1(dec_opcode);
    assign rs2_used = opc_uses_rs2(dec_opcode);

    assign load_use = dec_valid && ex_q.valid && ex_q.is_load && ex_q.wr &&
                      ((rs1_used && (ex_q.rd == dec_rs1)) ||
                       (rs2_used && (ex_q.rd == dec_rs2)));

    // branch_taken is only honoured in RUN; in FLUSH it comes from a squashed bubble
    assign flush_req = (state_q == StFlush) || branch_taken;
    assign flush     = rst_n && flush_req;
    assign stall     = rst_n && load_use && !flush_req;

    always_comb begin
        ex_d = '0;
        if (dec_valid && !stall && !flush) begin
            ex_d.valid   = 1'b1;
            ex_d.rd      = dec_rd;
            ex_d.wr      = opc_writes_rd(dec_opcode) && (dec_rd != 5'd0);
            ex_d.is_load = (dec_opcode == LOAD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Current EX is about to become MEM and current MEM is about to become WB.
    fwd_cmp u_fwd_rs1 (
        .rs       (dec_rs1),
        .mem_slot (ex_q),
        .wb_slot  (mem_q),
        .fwd_mem  (rs1_mem),
        .fwd_wb   (rs1_wb)
    );

    fwd_cmp u_fwd_rs2 (
        .rs       (dec_rs2),
        .mem_slot (ex_q),
        .wb_slot  (mem_q),
        .fwd_mem  (rs2_mem),
        .fwd_wb   (rs2_wb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            forward_mem_ex_rs1 <= 1'b0;
            forward_mem_ex_rs2 <= 1'b0;
            forward_wb_ex_rs1  <= 1'b0;
            forward_wb_ex_rs2  <= 1'b0;
        end else begin
            forward_mem_ex_rs1 <= ex_d.valid && rs1_mem;
            forward_mem_ex_rs2 <= ex_d.valid && rs2_mem;
            forward_wb_ex_rs1  <= ex_d.valid && rs1_wb;
            forward_wb_ex_rs2  <= ex_d.valid && rs2_wb;
        end
    end

    // FLUSH is left as the counter reaches 0, so flush spans FLUSH_CYCLES cycles
    // counting the branch_taken cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= 3'd0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (branch_taken) begin
                        cnt_q <= FlushLoad;
                        if (FlushLoad != 3'd0) state_q <= StFlush;
                    end
                end
                StFlush: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) state_q <= StRun;
                end
            endcase
        end
    end

    assign unused_wb = ^wb_q;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
            if (flush && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus random instruction streams
// checked against an instruction-history reference model.
module tb_hazard_ctrl;

    localparam int unsigned FC = 2;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dec_valid;
    logic [6:0] dec_opcode;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       branch_taken;
    logic       forward_mem_ex_rs1, forward_mem_ex_rs2;
    logic       forward_wb_ex_rs1, forward_wb_ex_rs2;
    logic       stall, flush;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .dec_valid          (dec_valid),
        .dec_opcode         (dec_opcode),
        .dec_rs1            (dec_rs1),
        .dec_rs2            (dec_rs2),
        .dec_rd             (dec_rd),
        .branch_taken       (branch_taken),
        .forward_mem_ex_rs1 (forward_mem_ex_rs1),
        .forward_mem_ex_rs2 (forward_mem_ex_rs2),
        .forward_wb_ex_rs1  (forward_wb_ex_rs1),
        .forward_wb_ex_rs2  (forward_wb_ex_rs2),
        .stall              (stall),
`ifdef HAZARD_PERF_EN
        .stall_cnt          (stall_cnt),
        .flush_cnt          (flush_cnt),
`endif
        .flush              (flush)
    );

    // Reference model: history of instructions accepted into EX, youngest first.
    typedef struct {
        bit valid;
        int rd;
        bit wr;
        bit ld;
    } instr_t;

    instr_t      hist[$];
    int          checks = 0;
    int          errors = 0;
    bit          e_fm1, e_fm2, e_fw1, e_fw2, e_stall, e_flush;
    int          flush_left;
    logic [31:0] n_stall, n_flush;
    logic [6:0]  ops [9] = '{LOAD, OP_IMM, OP, LUI, AUIPC, JAL, JALR, STORE, BRANCH};

    function automatic bit writes(input logic [6:0] op);
        return op inside {LOAD, OP_IMM, OP, LUI, AUIPC, JAL, JALR};
    endfunction

    function automatic bit uses1(input logic [6:0] op);
        return !(op inside {LUI, AUIPC, JAL});
    endfunction

    function automatic bit uses2(input logic [6:0] op);
        return op inside {OP, STORE, BRANCH};
    endfunction

    function automatic bit hits(input instr_t e, input logic [4:0] rs);
        return e.valid && e.wr && (e.rd == int'(rs));
    endfunction

    function automatic bit load_use();
        instr_t ex;
        ex = hist[0];
        if (!dec_valid || !ex.valid || !ex.ld || !ex.wr) return 1'b0;
        return (uses1(dec_opcode) && ex.rd == int'(dec_rs1)) ||
               (uses2(dec_opcode) && ex.rd == int'(dec_rs2));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        instr_t b;
        b = '{valid: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
        hist.delete();
        repeat (3) hist.push_back(b);
        {e_fm1, e_fm2, e_fw1, e_fw2} = '0;
        flush_left = 0;
        n_stall = '0;
        n_flush = '0;
    endtask

    task automatic drive(input bit v, input logic [6:0] op, input int rd, input int rs1,
                         input int rs2, input bit bt);
        dec_valid    = v;
        dec_opcode   = op;
        dec_rd       = 5'(rd);
        dec_rs1      = 5'(rs1);
        dec_rs2      = 5'(rs2);
        branch_taken = bt;
    endtask

    task automatic idle();
        drive(1'b0, OP_IMM, 0, 0, 0, 1'b0);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        instr_t n;
        #1;
        e_flush = (flush_left > 0) || branch_taken;
        e_stall = !e_flush && load_use();
        check("stall", stall, e_stall);
        check("flush", flush, e_flush);
        check("fwd_mem_rs1", forward_mem_ex_rs1, e_fm1);
        check("fwd_wb_rs1", forward_wb_ex_rs1, e_fw1);
        check("fwd_mem_rs2", forward_mem_ex_rs2, e_fm2);
        check("fwd_wb_rs2", forward_wb_ex_rs2, e_fw2);
`ifdef HAZARD_PERF_EN
        check("stall_cnt", stall_cnt, n_stall);
        check("flush_cnt", flush_cnt, n_flush);
`endif
        @(posedge clk);
        n = '{valid: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
        if (dec_valid && !e_stall && !e_flush) begin
            n.valid = 1'b1;
            n.rd    = int'(dec_rd);
            n.wr    = writes(dec_opcode) && dec_rd != 5'd0;
            n.ld    = (dec_opcode == LOAD);
            e_fm1 = hits(hist[0], dec_rs1);
            e_fw1 = !e_fm1 && hits(hist[1], dec_rs1);
            e_fm2 = hits(hist[0], dec_rs2);
            e_fw2 = !e_fm2 && hits(hist[1], dec_rs2);
        end else begin
            {e_fm1, e_fm2, e_fw1, e_fw2} = '0;
        end
        hist.push_front(n);
        void'(hist.pop_back());
        if (flush_left > 0) flush_left--;
        else if (branch_taken) flush_left = FC - 1;
        if (e_stall) n_stall++;
        if (e_flush) n_flush++;
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input bit fm1, input bit fw1, input bit fm2,
                              input bit fw2, input bit st, input bit fl);
        #1;
        check({tag, "_fm1"}, forward_mem_ex_rs1, fm1);
        check({tag, "_fw1"}, forward_wb_ex_rs1, fw1);
        check({tag, "_fm2"}, forward_mem_ex_rs2, fm2);
        check({tag, "_fw2"}, forward_wb_ex_rs2, fw2);
        check({tag, "_stall"}, stall, st);
        check({tag, "_flush"}, flush, fl);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        drive(1'b1, LOAD, 5, 1, 2, 1'b1);
        model_reset();
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        expect_out("reset_held", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step();

        // ADD x5,x1,x2 ; ADD x6,x5,x3
        drive(1, OP, 5, 1, 2, 0); step();
        drive(1, OP, 6, 5, 3, 0); step();
        idle(); expect_out("mem_fwd", 1, 0, 0, 0, 0, 0); step(); step(); step();

        // ADD x5 ; NOP ; SUB x7,x4,x5
        drive(1, OP, 5, 1, 2, 0); step();
        drive(1, OP_IMM, 0, 0, 0, 0); step();
        drive(1, OP, 7, 4, 5, 0); step();
        idle(); expect_out("wb_fwd", 0, 0, 0, 1, 0, 0); step(); step(); step();

        // ADD x5 twice ; OR x8,x5,x5
        drive(1, OP, 5, 1, 2, 0); step();
        drive(1, OP, 5, 3, 4, 0); step();
        drive(1, OP, 8, 5, 5, 0); step();
        idle(); expect_out("mem_prio", 1, 0, 1, 0, 0, 0); step(); step(); step();

        // LW x9,0(x1) ; ADD x10,x9,x0
        drive(1, LOAD, 9, 1, 0, 0); step();
        drive(1, OP, 10, 9, 0, 0);
        expect_out("lu_stall", 0, 0, 0, 0, 1, 0); step();
        expect_out("lu_bubble", 0, 0, 0, 0, 0, 0); step();
        idle(); expect_out("lu_fwd", 0, 1, 0, 0, 0, 0); step(); step(); step();

        // Branch taken colliding with a load-use hazard
        drive(1, LOAD, 9, 1, 0, 0); step();
        drive(1, OP, 10, 9, 0, 1);
        expect_out("br_cycle", 0, 0, 0, 0, 0, 1); step();
        idle(); expect_out("br_flush2", 0, 0, 0, 0, 0, 1); step();
        expect_out("br_done", 0, 0, 0, 0, 0, 0); step(); step();

        // ADDI x0,x0,1 ; ADD x1,x0,x0
        drive(1, OP_IMM, 0, 0, 0, 0); step();
        drive(1, OP, 1, 0, 0, 0); step();
        idle(); expect_out("x0", 0, 0, 0, 0, 0, 0); step(); step();

        // Reset during a stall with a forward flag set
        drive(1, OP, 1, 2, 3, 0); step();
        drive(1, LOAD, 9, 1, 0, 0); step();
        drive(1, OP, 10, 9, 0, 0);
        expect_out("pre_rst_stall", 1, 0, 0, 0, 1, 0);
        rst_n = 1'b0;
        expect_out("rst_stall", 0, 0, 0, 0, 0, 0);
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Reset in the middle of a flush
        drive(0, OP_IMM, 0, 0, 0, 1); step();
        idle();
        expect_out("pre_rst_flush", 0, 0, 0, 0, 0, 1);
        rst_n = 1'b0;
        expect_out("rst_flush", 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();

        for (int i = 0; i < 400; i++) begin
            if (!e_stall) begin
                dec_valid  = ($urandom_range(0, 4) != 0);
                k          = $urandom_range(0, 9);
                dec_opcode = (k == 9) ? 7'($urandom) : ops[k];
                dec_rd     = 5'($urandom_range(0, 3));
                dec_rs1    = 5'($urandom_range(0, 3));
                dec_rs2    = 5'($urandom_range(0, 3));
            end
            branch_taken = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that sequences the execute stage. It keeps a shadow scoreboard of the instructions in EX, MEM and WB. From that scoreboard it drives the four forwarding selects consumed by `exec`, a one-cycle load-use stall, and a multi-cycle flush after a taken branch or jump. It sits beside the decode→execute boundary and is the only source of the `forward_*` and `stall`/`flush` controls.

## Interface
- `FLUSH_CYCLES`, default 2: bubbles inserted after `branch_taken`; legal range 1..7.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `dec_valid` in 1: decode presents an instruction this cycle.
- `dec_opcode` in 7: opcode of the decoded instruction.
- `dec_rs1`, `dec_rs2` in 5 each: source register indices.
- `dec_rd` in 5: destination register index.
- `branch_taken` in 1: from `exec`; redirect resolved this cycle.
- `forward_mem_ex_rs1`, `forward_mem_ex_rs2` out 1 each: select `rdMem` for rs1/rs2 in EX.
- `forward_wb_ex_rs1`, `forward_wb_ex_rs2` out 1 each: select `rdWb` for rs1/rs2 in EX.
- `stall` out 1: hold PC and the IF/ID register; a bubble enters EX.
- `flush` out 1: invalidate IF/ID; a bubble enters EX.

## Operation
- Scoreboard has three slots: EX, MEM, WB. Each slot holds {valid, rd, wr, is_load}.
- The scoreboard advances every cycle (EX→MEM→WB).
- EX loads the decoded instruction, or a bubble (valid=0) when `stall`, `flush` or `!dec_valid`.
- `wr` = 1 for LOAD, OP-IMM, OP, LUI, AUIPC, JAL and JALR. `wr` = 0 for STORE and BRANCH.
- `wr` is forced to 0 when rd==0.
- rs1 is used by all opcodes except LUI, AUIPC and JAL.
- rs2 is used only by OP, STORE and BRANCH.
- Forwarding: on each advancing edge, the rs1 flags are registered by comparing `dec_rs1` against the slot that is moving into MEM (the current EX slot) and the slot moving into WB (the current MEM slot). rs2 uses the same rule.
- MEM match has priority: when both MEM and WB match, only `forward_mem_*` = 1.
- A flag is set only if the slot is valid, has `wr`=1, and rd == rs.
- Flags for a bubble entering EX are 0.
- Load-use: if the current EX slot is valid with is_load=1, and its rd equals a *used* rs of a valid decode, then `stall`=1 combinationally in that cycle.
- After the stall cycle the load sits in MEM and data arrives via the WB path next cycle; the flags are recomputed accordingly.
- Flush FSM states are RUN and FLUSH.
  - RUN→FLUSH when `branch_taken`=1. The counter loads FLUSH_CYCLES-1.
  - `flush`=1 in the `branch_taken` cycle and in every FLUSH cycle.
  - In FLUSH the counter decrements each cycle; FLUSH→RUN when the counter is 0.
  - `branch_taken` in FLUSH is ignored; it comes from a squashed bubble and cannot be valid.
- Priority: flush > stall. When `branch_taken` and a load-use hazard coincide, `stall`=0 and `flush`=1.

## Timing
- Reset (asynchronous, `rst_n`=0): all slots invalid, FSM=RUN, counter=0, all forward flags 0. `stall` and `flush` read 0 while reset is held.
- Forward flags: registered, with 1-cycle latency from decode. They are stable for the whole cycle in which `exec` samples operands.
- `stall` and `flush`: combinational from the current slots, decode and FSM. They take effect at the next edge.
- Reset asserted mid-flush or mid-stall aborts it immediately. There are no pending bubbles after release.
- rd/rs comparisons are 5-bit equality. x0 never matches because its `wr` is forced to 0.

## Configuration
- `HAZARD_PERF_EN` defined: adds outputs `stall_cnt` out 32 and `flush_cnt` out 32.
  - Each counter increments once per cycle in which `stall` (resp. `flush`) = 1.
  - Counters saturate at 0xFFFF_FFFF and reset to 0.
- `HAZARD_PERF_EN` undefined: no counter ports or logic. Behaviour is otherwise identical.

## Structure
- The shared package `core_pkg` holds:
  - the opcode constants (LOAD=7'b0000011, OP_IMM=7'b0010011, OP=7'b0110011, LUI=7'b0110111, AUIPC=7'b0010111, JAL=7'b1101111, JALR=7'b1100111, STORE=7'b0100011, BRANCH=7'b1100011);
  - the slot struct `sb_slot_t`;
  - the FSM enum `flush_state_t`.
- One sub-module, `fwd_cmp`, is natural: it takes one rs index plus the MEM and WB slots and returns the {mem, wb} select pair. It is instantiated twice, once for rs1 and once for rs2.

## Test plan
- ADD x5,x1,x2 then ADD x6,x5,x3 back-to-back → second instr in EX: `forward_mem_ex_rs1`=1, others 0, `stall`=0.
- ADD x5; NOP; SUB x7,x4,x5 → SUB in EX: `forward_wb_ex_rs2`=1, `forward_mem_ex_rs2`=0.
- ADD x5 twice, then OR x8,x5,x5 → MEM priority: `forward_mem_ex_rs1`=`forward_mem_ex_rs2`=1, wb flags 0.
- LW x9,0(x1) then ADD x10,x9,x0 → `stall`=1 for exactly 1 cycle, bubble in EX. The ADD then gets `forward_wb_ex_rs1`=1.
- `branch_taken` pulse with FLUSH_CYCLES=2 → `flush`=1 for 2 cycles and 2 bubbles. A simultaneous load-use hazard yields `stall`=0. With `HAZARD_PERF_EN`, `flush_cnt`=2.
- ADDI x0,x0,1 then ADD x1,x0,x0 → no forward flags set. `rst_n` dropped mid-flush → `flush`=0 and flags 0 immediately.
